// File: rtl/nf_bus_rmw_pkg.sv
// nf_bus_rmw_pkg: widths and the write-value helper for nf_bus_rmw.
//   NF_DW                - bus data/address width
//   NF_CNT_W             - width of the read-hold counter (wait_cyc 0..15)
//   nf_rmw_new_value()   - value written back for an operation
`include "nf_settings.svh"

package nf_bus_rmw_pkg;

  localparam int unsigned NF_DW    = 32;
  localparam int unsigned NF_CNT_W = 4;

  // WR writes the command data; MOD merges under mask; TGL flips masked bits.
  // RD never writes, so its result here is irrelevant.
  function automatic logic [NF_DW-1:0] nf_rmw_new_value(
    input logic [1:0]       op,
    input logic [NF_DW-1:0] old_val,
    input logic [NF_DW-1:0] wr_val,
    input logic [NF_DW-1:0] mask
  );
    case (op)
      `NF_RMW_MOD: return (old_val & ~mask) | (wr_val & mask);
      `NF_RMW_TGL: return old_val ^ mask;
      default:     return wr_val;
    endcase
  endfunction

endpackage

// File: rtl/nf_settings.svh
// Shared settings for the NF bus blocks.
// Operation codes carried on cmd_op of nf_bus_rmw.
`ifndef NF_SETTINGS_SVH
`define NF_SETTINGS_SVH

`define NF_RMW_WR  2'b00
`define NF_RMW_RD  2'b01
`define NF_RMW_MOD 2'b10
`define NF_RMW_TGL 2'b11

`endif

// File: rtl/nf_bus_rmw.sv
// nf_bus_rmw: single-command bus read-modify-write engine.
// A command is captured in IDLE, the target word is read (held wait_cyc+1
// cycles), optionally written back once, and completion is pulsed.
// Ports:
//   clk, resetn           - clock, asynchronous active-low reset
//   cmd_req/op/addr/wd/mask - command request and fields (sampled in IDLE)
//   cmd_ack               - pulse: command captured
//   rsp_valid, rsp_rd     - completion pulse, pre-operation read value
//   busy                  - high outside IDLE
//   addr, we, wd, rd      - bus master side (rd combinational from responder)
`include "nf_settings.svh"

module nf_bus_rmw
  import nf_bus_rmw_pkg::*;
#(
  parameter int unsigned wait_cyc = 0
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             cmd_req,
  input  logic [1:0]       cmd_op,
  input  logic [NF_DW-1:0] cmd_addr,
  input  logic [NF_DW-1:0] cmd_wd,
  input  logic [NF_DW-1:0] cmd_mask,
  output logic             cmd_ack,
  output logic             rsp_valid,
  output logic [NF_DW-1:0] rsp_rd,
  output logic             busy,
  output logic [NF_DW-1:0] addr,
  output logic             we,
  output logic [NF_DW-1:0] wd,
  input  logic [NF_DW-1:0] rd
);

  localparam logic [NF_CNT_W-1:0] WAIT_LAST = NF_CNT_W'(wait_cyc);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_RESP
  } state_e;

  state_e              state_q, state_d;
  logic [NF_CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]          op_q, op_d;
  logic [NF_DW-1:0]    addr_q, addr_d;
  logic [NF_DW-1:0]    wd_q, wd_d;
  logic [NF_DW-1:0]    mask_q, mask_d;
  logic [NF_DW-1:0]    old_q, old_d;
  logic [NF_DW-1:0]    rsp_rd_q, rsp_rd_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    addr_d    = addr_q;
    wd_d      = wd_q;
    mask_d    = mask_q;
    old_d     = old_q;
    rsp_rd_d  = rsp_rd_q;
    cmd_ack   = 1'b0;
    rsp_valid = 1'b0;
    we        = 1'b0;
    addr      = '0;
    wd        = '0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_req) begin
          // Reset holds the FSM in IDLE; gate so no ack escapes during reset.
          cmd_ack = resetn;
          op_d    = cmd_op;
          addr_d  = cmd_addr;
          wd_d    = cmd_wd;
          mask_d  = cmd_mask;
          state_d = (cmd_op == `NF_RMW_WR) ? ST_WRITE : ST_READ;
        end
      end
      ST_READ: begin
        addr = addr_q;
        if (cnt_q == WAIT_LAST) begin
          cnt_d = '0;
          old_d = rd;
          if (op_q == `NF_RMW_RD) begin
            // Pure reads finish here; response value loads on the way to RESP.
            rsp_rd_d = rd;
            state_d  = ST_RESP;
          end else begin
            state_d  = ST_WRITE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WRITE: begin
        we       = 1'b1;
        addr     = addr_q;
        wd       = nf_rmw_new_value(op_q, old_q, wd_q, mask_q);
        rsp_rd_d = (op_q == `NF_RMW_WR) ? '0 : old_q;
        state_d  = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      addr_q   <= '0;
      wd_q     <= '0;
      mask_q   <= '0;
      old_q    <= '0;
      rsp_rd_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      addr_q   <= addr_d;
      wd_q     <= wd_d;
      mask_q   <= mask_d;
      old_q    <= old_d;
      rsp_rd_q <= rsp_rd_d;
    end
  end

  assign busy   = (state_q != ST_IDLE);
  assign rsp_rd = rsp_rd_q;

endmodule

// File: tb/tb_nf_bus_rmw.sv
// tb_nf_bus_rmw: directed bench for nf_bus_rmw with two instances
// (wait_cyc 0 and 3), each on a 16-word responder memory.
module tb_nf_bus_rmw;

  localparam logic [1:0] OP_WR  = 2'b00;
  localparam logic [1:0] OP_RD  = 2'b01;
  localparam logic [1:0] OP_MOD = 2'b10;
  localparam logic [1:0] OP_TGL = 2'b11;

  logic        clk;
  logic        resetn;
  logic        preload;
  logic        req   [2];
  logic [1:0]  op    [2];
  logic [31:0] caddr [2];
  logic [31:0] cwd   [2];
  logic [31:0] cmask [2];
  logic        ack   [2];
  logic        rv    [2];
  logic [31:0] rrd   [2];
  logic        busy  [2];
  logic [31:0] baddr [2];
  logic        we    [2];
  logic [31:0] bwd   [2];
  logic [31:0] brd   [2];

  logic [31:0] mem   [2][16];
  logic [31:0] model [2][16];

  typedef struct {
    logic [31:0] rsp;
    int          lat;
    int          wes;
    logic [31:0] wval;
    int          acyc;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  nf_bus_rmw #(.wait_cyc(0)) dut0 (
    .clk(clk), .resetn(resetn),
    .cmd_req(req[0]), .cmd_op(op[0]), .cmd_addr(caddr[0]), .cmd_wd(cwd[0]),
    .cmd_mask(cmask[0]), .cmd_ack(ack[0]), .rsp_valid(rv[0]), .rsp_rd(rrd[0]),
    .busy(busy[0]), .addr(baddr[0]), .we(we[0]), .wd(bwd[0]), .rd(brd[0])
  );

  nf_bus_rmw #(.wait_cyc(3)) dut1 (
    .clk(clk), .resetn(resetn),
    .cmd_req(req[1]), .cmd_op(op[1]), .cmd_addr(caddr[1]), .cmd_wd(cwd[1]),
    .cmd_mask(cmask[1]), .cmd_ack(ack[1]), .rsp_valid(rv[1]), .rsp_rd(rrd[1]),
    .busy(busy[1]), .addr(baddr[1]), .we(we[1]), .wd(bwd[1]), .rd(brd[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Responders: combinational read, synchronous write.
  assign brd[0] = mem[0][baddr[0][3:0]];
  assign brd[1] = mem[1][baddr[1][3:0]];

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 2; i++)
        for (int j = 0; j < 16; j++) mem[i][j] <= '0;
      mem[0][4] <= 32'h0000_00F0;
      mem[0][8] <= 32'hFFFF_0000;
      mem[1][3] <= 32'h5A5A_0003;
    end else begin
      if (we[0]) mem[0][baddr[0][3:0]] <= bwd[0];
      if (we[1]) mem[1][baddr[1][3:0]] <= bwd[1];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_new(input logic [1:0] o, input logic [31:0] pre,
                                            input logic [31:0] w, input logic [31:0] m);
    case (o)
      OP_WR:   return w;
      OP_MOD:  return (pre & ~m) | (w & m);
      OP_TGL:  return pre ^ m;
      default: return pre;
    endcase
  endfunction

  // Called at a drive point (just after a rising edge) with the DUT idle.
  task automatic run_op(input int d, input logic [1:0] o, input logic [3:0] a,
                        input logic [31:0] w, input logic [31:0] m, input string tag);
    int          wc, n, wes, acyc, got;
    logic [31:0] pre, nv, wv;
    exp_t        e;
    wc  = (d == 1) ? 3 : 0;
    pre = model[d][a];
    nv  = model_new(o, pre, w, m);
    e.rsp  = (o == OP_WR) ? 32'h0 : pre;
    e.lat  = (o == OP_WR) ? 2 : (o == OP_RD) ? 2 + wc : 3 + wc;
    e.wes  = (o == OP_RD) ? 0 : 1;
    e.wval = (o == OP_RD) ? 32'h0 : nv;
    e.acyc = ((o == OP_WR) ? 0 : wc + 1) + ((o == OP_RD) ? 0 : 1);
    sb.push_back(e);
    model[d][a] = nv;

    req[d] = 1'b1; op[d] = o; caddr[d] = {28'h0, a}; cwd[d] = w; cmask[d] = m;
    #1;
    chk({tag, "_ack"}, {31'h0, ack[d]}, 32'h1);
    n = 0; wes = 0; acyc = 0; got = 0; wv = '0;
    while (got == 0 && n < 40) begin
      @(posedge clk); #1;
      if (n == 0) begin
        // Command fields change after capture; the running op must not notice.
        req[d] = 1'b0; op[d] = ~o; caddr[d] = $urandom; cwd[d] = $urandom; cmask[d] = $urandom;
      end
      #1;
      n++;
      if (we[d]) begin wes++; wv = bwd[d]; end
      if (busy[d] && !rv[d] && baddr[d] === {28'h0, a}) acyc++;
      if (rv[d]) got = 1;
    end
    chk({tag, "_rsp_seen"}, got, 1);
    if (got != 0) begin
      e = sb.pop_front();
      chk({tag, "_rsp_rd"},  rrd[d], e.rsp);
      chk({tag, "_latency"}, n, e.lat);
      chk({tag, "_we_count"}, wes, e.wes);
      chk({tag, "_wr_data"}, wv, e.wval);
      chk({tag, "_addr_cycles"}, acyc, e.acyc);
      chk({tag, "_resp_bus"}, {we[d], baddr[d] | bwd[d]}, 33'h0);
    end
    @(posedge clk); #1;
    chk({tag, "_idle_busy"}, {31'h0, busy[d]}, 32'h0);
    chk({tag, "_mem"}, mem[d][a], model[d][a]);
  endtask

  logic [1:0]  h_op   [3] = '{OP_RD, OP_TGL, OP_RD};
  logic [3:0]  h_addr [3] = '{4'h0, 4'h8, 4'h8};
  logic [31:0] h_mask [3] = '{32'h0, 32'h0000_00FF, 32'h0};
  int          h_ack_exp [3] = '{0, 3, 7};
  int          h_rv_exp  [3] = '{2, 6, 9};

  initial begin
    int          acks, rvs, bad;
    int          ack_t [4];
    int          rv_t  [4];
    logic [31:0] snap, pre;
    exp_t        e;

    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b0; op[i] = '0; caddr[i] = '0; cwd[i] = '0; cmask[i] = '0;
      for (int j = 0; j < 16; j++) model[i][j] = '0;
    end
    model[0][4] = 32'h0000_00F0;
    model[0][8] = 32'hFFFF_0000;
    model[1][3] = 32'h5A5A_0003;

    // Reset state, including a request present during reset.
    resetn = 1'b0; preload = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    req[0] = 1'b1; op[0] = OP_WR;
    #1;
    chk("rst_ack", {31'h0, ack[0]}, 32'h0);
    chk("rst_outs", {rv[0], busy[0], we[0], busy[1]}, 32'h0);
    chk("rst_bus", baddr[0] | bwd[0] | rrd[0], 32'h0);
    req[0] = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1; preload = 1'b0;
    @(posedge clk); #1;

    run_op(0, OP_MOD, 4'h4, 32'h0000_000A, 32'h0000_000F, "mod");
    chk("mod_mem_fa", mem[0][4], 32'h0000_00FA);
    run_op(0, OP_TGL, 4'h8, 32'h0, 32'h0000_FFFF, "tgl");
    chk("tgl_mem", mem[0][8], 32'hFFFF_FFFF);
    run_op(0, OP_WR, 4'h0, 32'h1234_5678, $urandom, "wr");
    run_op(0, OP_RD, 4'h0, $urandom, $urandom, "rd");
    chk("rd_value", rrd[0], 32'h1234_5678);
    run_op(1, OP_RD, 4'h3, 32'h0, 32'h0, "w3_rd");
    run_op(1, OP_MOD, 4'h3, 32'h0000_FFFF, 32'h00FF_00FF, "w3_mod");

    // Request held high across three commands; fields change after each ack.
    acks = 0; rvs = 0;
    req[0] = 1'b1; op[0] = h_op[0]; caddr[0] = {28'h0, h_addr[0]}; cwd[0] = '0; cmask[0] = h_mask[0];
    for (int c = 0; c < 13; c++) begin
      #1;
      if (ack[0]) begin
        if (acks < 3) begin
          ack_t[acks] = c;
          pre = model[0][h_addr[acks]];
          e.rsp = pre; e.lat = 0; e.wes = 0; e.wval = '0; e.acyc = 0;
          sb.push_back(e);
          model[0][h_addr[acks]] = model_new(h_op[acks], pre, 32'h0, h_mask[acks]);
        end
        acks++;
      end
      if (rv[0]) begin
        if (rvs < 3 && sb.size() > 0) begin
          rv_t[rvs] = c;
          e = sb.pop_front();
          chk("held_rsp_rd", rrd[0], e.rsp);
        end
        rvs++;
      end
      @(posedge clk); #1;
      if (acks < 3) begin
        op[0] = h_op[acks]; caddr[0] = {28'h0, h_addr[acks]}; cmask[0] = h_mask[acks];
      end else begin
        req[0] = 1'b0;
      end
    end
    chk("held_ack_count", acks, 3);
    chk("held_rsp_count", rvs, 3);
    if (acks == 3 && rvs == 3) begin
      for (int k = 0; k < 3; k++) begin
        chk("held_ack_cycle", ack_t[k], h_ack_exp[k]);
        chk("held_rsp_cycle", rv_t[k], h_rv_exp[k]);
      end
    end
    chk("held_mem8", mem[0][8], model[0][8]);

    // Reset during the READ phase of a MOD.
    snap = mem[0][4];
    req[0] = 1'b1; op[0] = OP_MOD; caddr[0] = 32'h4; cwd[0] = 32'h0000_0055; cmask[0] = 32'hFFFF_FFFF;
    #1;
    chk("abort_ack", {31'h0, ack[0]}, 32'h1);
    @(posedge clk); #1;
    req[0] = 1'b0;
    chk("abort_in_read", {busy[0], we[0], baddr[0][3:0]}, {1'b1, 1'b0, 4'h4});
    resetn = 1'b0;
    #1;
    chk("abort_outs", {ack[0], rv[0], busy[0], we[0]}, 32'h0);
    chk("abort_bus", baddr[0] | bwd[0] | rrd[0], 32'h0);
    @(posedge clk); #1;
    resetn = 1'b1;
    bad = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #2;
      if (rv[0] || we[0] || busy[0]) bad++;
    end
    chk("abort_no_activity", bad, 0);
    chk("abort_mem", mem[0][4], snap);
    chk("abort_mem_model", mem[0][4], model[0][4]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
